// File: rtl/multicycle_control_fsm_pkg.sv
// ============================================================================
// Module      : multicycle_control_fsm_pkg
// Description : Shared encodings for the multicycle RV32I-subset control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_fsm_pkg;

  localparam int c_STATE_W  = 4;
  localparam int c_ALUCTL_W = 3;

  typedef enum logic [c_STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // ALU opcode bus values; these must track the ALU's own decode.
  typedef logic [c_ALUCTL_W-1:0] alu_op_t;
  localparam alu_op_t c_ALU_ADD = 3'b000;
  localparam alu_op_t c_ALU_SUB = 3'b001;
  localparam alu_op_t c_ALU_AND = 3'b010;
  localparam alu_op_t c_ALU_OR  = 3'b011;
  localparam alu_op_t c_ALU_XOR = 3'b100;
  localparam alu_op_t c_ALU_SRL = 3'b101;
  localparam alu_op_t c_ALU_SLL = 3'b110;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [1:0] c_SRC_A_PC    = 2'b00;
  localparam logic [1:0] c_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] c_SRC_A_RS1   = 2'b10;

  localparam logic [1:0] c_SRC_B_RS2   = 2'b00;
  localparam logic [1:0] c_SRC_B_IMM   = 2'b01;
  localparam logic [1:0] c_SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] c_RES_ALUOUT  = 2'b00;
  localparam logic [1:0] c_RES_MEMDATA = 2'b01;
  localparam logic [1:0] c_RES_ALURES  = 2'b10;

  localparam logic [1:0] c_IMM_I = 2'b00;
  localparam logic [1:0] c_IMM_S = 2'b01;
  localparam logic [1:0] c_IMM_B = 2'b10;
  localparam logic [1:0] c_IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ============================================================================
// Module      : multicycle_control_fsm_alu_decoder
// Description : Combinational funct decode to ALU op plus legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       f7_5,
  output alu_op_t    alu_control,
  output logic       funct_illegal
);

  logic w_is_r;

  assign w_is_r = (opcode == c_OP_R);

  // Unknown opcodes are flagged here too so DECODE needs a single trap test.
  always_comb begin
    alu_control   = c_ALU_ADD;
    funct_illegal = 1'b0;
    case (opcode)
      c_OP_R, c_OP_I: begin
        case (f3)
          3'b000: alu_control = (w_is_r && f7_5) ? c_ALU_SUB : c_ALU_ADD;
          3'b111: begin
            alu_control   = c_ALU_AND;
            funct_illegal = w_is_r && f7_5;
          end
          3'b110: begin
            alu_control   = c_ALU_OR;
            funct_illegal = w_is_r && f7_5;
          end
          3'b100: begin
            alu_control   = c_ALU_XOR;
            funct_illegal = w_is_r && f7_5;
          end
          3'b001: begin
            alu_control   = c_ALU_SLL;
            funct_illegal = f7_5;
          end
          3'b101: begin
            alu_control   = c_ALU_SRL;
            funct_illegal = f7_5;
          end
          default: funct_illegal = 1'b1;
        endcase
      end
      c_OP_LOAD, c_OP_STORE: funct_illegal = (f3 != 3'b010);
      c_OP_BRANCH: begin
        alu_control   = c_ALU_SUB;
        funct_illegal = (f3 != 3'b000) && (f3 != 3'b001);
      end
      c_OP_JAL: funct_illegal = 1'b0;
      default:  funct_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle RV32I-subset main control unit (state + strobes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [1:0]          imm_src,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_write,
  output logic                illegal_instr,
  output logic [STATE_W-1:0]  state_dbg
);

  state_t     r_state;
  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  alu_op_t    w_funct_op;
  logic       w_funct_illegal;
  logic       w_unused_instr_bits;

  assign w_opcode            = instr[6:0];
  assign w_f3                = instr[14:12];
  assign w_unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  multicycle_control_fsm_alu_decoder u_alu_decoder (
    .opcode        (w_opcode),
    .f3            (w_f3),
    .f7_5          (instr[30]),
    .alu_control   (w_funct_op),
    .funct_illegal (w_funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_funct_illegal) begin
            r_state <= S_ILLEGAL;
          end else begin
            case (w_opcode)
              c_OP_LOAD, c_OP_STORE: r_state <= S_MEMADR;
              c_OP_R:                r_state <= S_EXECR;
              c_OP_I:                r_state <= S_EXECI;
              c_OP_JAL:              r_state <= S_JAL;
              c_OP_BRANCH:           r_state <= S_BRANCH;
              default:               r_state <= S_ILLEGAL;
            endcase
          end
        end
        // Opcode bit 5 is the only difference between lw and sw.
        S_MEMADR:   r_state <= w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_BRANCH:   r_state <= S_FETCH;
        S_ILLEGAL:  r_state <= S_ILLEGAL;
        default:    r_state <= S_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    case (w_opcode)
      c_OP_STORE:  imm_src = c_IMM_S;
      c_OP_BRANCH: imm_src = c_IMM_B;
      c_OP_JAL:    imm_src = c_IMM_J;
      default:     imm_src = c_IMM_I;
    endcase
  end

  always_comb begin
    alu_control   = c_ALU_ADD;
    alu_src_a     = c_SRC_A_PC;
    alu_src_b     = c_SRC_B_RS2;
    result_src    = c_RES_ALUOUT;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = c_SRC_B_FOUR;
        result_src = c_RES_ALURES;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = c_SRC_A_OLDPC;
        alu_src_b = c_SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = c_SRC_A_RS1;
        alu_src_b = c_SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = c_RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = c_SRC_A_RS1;
        alu_control = w_funct_op;
      end
      S_EXECI: begin
        alu_src_a   = c_SRC_A_RS1;
        alu_src_b   = c_SRC_B_IMM;
        alu_control = w_funct_op;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = c_SRC_A_OLDPC;
        alu_src_b = c_SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = c_SRC_A_RS1;
        alu_control = c_ALU_SUB;
        pc_write    = w_f3[0] ? ~alu_zero : alu_zero;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default:   illegal_instr = 1'b1;
    endcase
    // Reset overrides any in-flight strobe, even mid-instruction.
    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(r_state);

endmodule

`default_nettype wire
